// File: rtl/data_sram_resp.sv
// data_sram_resp: single-port 32-bit data SRAM with byte write enables and a
// registered read response.
// Optional feature macro: DSRAM_WAIT_EN. When defined, every access holds the
// port busy for WAIT_CYCLES extra cycles through an IDLE/WAIT/RESP FSM. When it
// is undefined, reads return one cycle later and busy is tied low.
module data_sram_resp #(
    parameter int ADDR_W      = 14,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_rvalid,
    output logic        data_sram_busy,
    output logic        addr_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    logic [31:0]       r_mem [2**ADDR_W];
    logic [31:0]       r_rdata;
    logic              r_rvalid;
    logic              r_addr_err;
    logic [31:0]       r_rd_cnt;
    logic [31:0]       r_wr_cnt;

    logic [ADDR_W-1:0] w_index;
    logic              w_oor;
    logic              w_is_wr;
    logic              w_busy;
    logic              w_accept;
    logic [31:0]       w_rd_word;
    logic [1:0]        w_unused_addr_lsb;

    // Byte offset within the word plays no part in addressing.
    assign w_unused_addr_lsb = data_sram_addr[1:0];

    assign w_index   = data_sram_addr[ADDR_W+1:2];
    assign w_oor     = |data_sram_addr[31:ADDR_W+2];
    assign w_is_wr   = |data_sram_we;
    // Requests seen while reset is high never reach the array or counters.
    assign w_accept  = data_sram_en & ~w_busy & ~reset;
    // Out-of-range reads return zero rather than an aliased word.
    assign w_rd_word = w_oor ? 32'h0 : r_mem[w_index];

    // Byte-lane write into the array, committed on the accepting edge.
    // NOTE: the array has no reset branch; contents must survive reset and a
    // reset would also stop the tools from mapping it onto RAM macros.
    always_ff @(posedge clk) begin
        if (w_accept && w_is_wr && !w_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) begin
                    r_mem[w_index][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Access counters and the sticky out-of-range flag.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_cnt   <= 32'h0;
            r_wr_cnt   <= 32'h0;
            r_addr_err <= 1'b0;
        end else if (w_accept) begin
            if (w_is_wr) r_wr_cnt <= r_wr_cnt + 32'h1;
            else         r_rd_cnt <= r_rd_cnt + 32'h1;
            if (w_oor)   r_addr_err <= 1'b1;
        end
    end

`ifdef DSRAM_WAIT_EN

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(WAIT_CYCLES + 2);

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]  w_next_wait_cnt;
    logic              r_pend_rd;
    logic [31:0]       r_pend_data;
    logic              w_fire;
    logic              w_fire_rd;
    logic [31:0]       w_fire_data;

    assign w_busy = (r_state != IDLE);

    // Response leaves on the edge that enters RESP. With no wait cycles that
    // edge is the accepting edge itself, so the live request is used.
    assign w_fire      = (w_next_state == RESP) && (r_state != RESP);
    assign w_fire_rd   = (r_state == IDLE) ? ~w_is_wr  : r_pend_rd;
    assign w_fire_data = (r_state == IDLE) ? w_rd_word : r_pend_data;

    // Next-state and wait-counter logic; the counter holds the WAIT cycles
    // still to run, including the current one.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state    = r_state;
        w_next_wait_cnt = r_wait_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next_state = RESP;
                    end else begin
                        w_next_state    = WAIT;
                        w_next_wait_cnt = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (r_wait_cnt <= CNT_W'(1)) begin
                    w_next_state    = RESP;
                    w_next_wait_cnt = '0;
                end else begin
                    w_next_wait_cnt = r_wait_cnt - CNT_W'(1);
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State register, pending-access capture and the read response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_pend_rd   <= 1'b0;
            r_pend_data <= 32'h0;
            r_rdata     <= 32'h0;
            r_rvalid    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait_cnt;
            if (w_accept) begin
                r_pend_rd   <= ~w_is_wr;
                r_pend_data <= w_rd_word;
            end
            r_rvalid <= w_fire & w_fire_rd;
            if (w_fire && w_fire_rd) r_rdata <= w_fire_data;
        end
    end

`else

    assign w_busy = 1'b0;

    // Single-cycle read response; rdata holds until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata  <= 32'h0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_accept & ~w_is_wr;
            if (w_accept && !w_is_wr) r_rdata <= w_rd_word;
        end
    end

`endif

    assign data_sram_rdata  = r_rdata;
    assign data_sram_rvalid = r_rvalid;
    assign data_sram_busy   = w_busy;
    assign addr_err         = r_addr_err;
    assign rd_cnt           = r_rd_cnt;
    assign wr_cnt           = r_wr_cnt;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp. Works with DSRAM_WAIT_EN either undefined
// (latency-1 tests) or defined (FSM tests, WAIT_CYCLES=2).
module tb_data_sram_resp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_we = 4'h0;
    logic [31:0] data_sram_addr = 32'h0;
    logic [31:0] data_sram_wdata = 32'h0;
    logic [31:0] data_sram_rdata;
    logic        data_sram_rvalid;
    logic        data_sram_busy;
    logic        addr_err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_sram_resp #(.ADDR_W(14), .WAIT_CYCLES(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .data_sram_en     (data_sram_en),
        .data_sram_we     (data_sram_we),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .data_sram_rdata  (data_sram_rdata),
        .data_sram_rvalid (data_sram_rvalid),
        .data_sram_busy   (data_sram_busy),
        .addr_err         (addr_err),
        .rd_cnt           (rd_cnt),
        .wr_cnt           (wr_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wd);
        data_sram_en    = en;
        data_sram_we    = we;
        data_sram_addr  = addr;
        data_sram_wdata = wd;
    endtask

    task automatic pulse_reset;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 10 && data_sram_busy; i++) tick();
        if (data_sram_busy) begin
            n_vec++; n_err++;
            $display("FAIL wait_idle: busy still %b after 10 cycles, want 0", data_sram_busy);
        end
    endtask

    task automatic do_write(input logic [3:0] we, input logic [31:0] addr,
                            input logic [31:0] wd);
        wait_idle();
        drive(1'b1, we, addr, wd);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output bit got);
        wait_idle();
        drive(1'b1, 4'h0, addr, 32'h0);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 8 && !data_sram_rvalid; i++) tick();
        got  = data_sram_rvalid;
        data = data_sram_rdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        bit          got;
        reset = 1'b1;
        drive(1'b1, 4'hF, 32'h100, 32'h5555AAAA);
        tick();
        tick();
        n_vec++; if (data_sram_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", data_sram_rdata); end
        n_vec++; if (data_sram_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b want 0", data_sram_rvalid); end
        n_vec++; if (data_sram_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", data_sram_busy); end
        n_vec++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
        n_vec++; if (rd_cnt !== 32'h0) begin n_err++; $display("FAIL reset_rd_cnt: got %h want 0", rd_cnt); end
        n_vec++; if (wr_cnt !== 32'h0) begin n_err++; $display("FAIL reset_wr_cnt: got %h want 0", wr_cnt); end
        reset = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        n_vec++; if (wr_cnt !== 32'h0) begin n_err++; $display("FAIL reset_en_ignored_cnt: got %h want 0", wr_cnt); end
        do_read(32'h100, d, got);
        n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL reset_read_rvalid: got %b want 1", got); end
        n_vec++; if (d === 32'h5555AAAA) begin n_err++; $display("FAIL reset_en_ignored_mem: got %h want not 5555aaaa", d); end
        n_vec++; if (rd_cnt !== 32'h1) begin n_err++; $display("FAIL reset_rd_cnt_after: got %h want 1", rd_cnt); end
        pulse_reset();
        n_vec++; if (rd_cnt !== 32'h0) begin n_err++; $display("FAIL reset_rd_cnt_clear: got %h want 0", rd_cnt); end
    endtask

`ifndef DSRAM_WAIT_EN
    task automatic test_basic;
        pulse_reset();
        drive(1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
        tick();
        n_vec++; if (data_sram_rvalid !== 1'b0) begin n_err++; $display("FAIL basic_wr_rvalid: got %b want 0", data_sram_rvalid); end
        n_vec++; if (data_sram_rdata !== 32'h0) begin n_err++; $display("FAIL basic_wr_rdata: got %h want 0", data_sram_rdata); end
        n_vec++; if (wr_cnt !== 32'h1) begin n_err++; $display("FAIL basic_wr_cnt: got %h want 1", wr_cnt); end
        drive(1'b1, 4'h0, 32'h40, 32'h0);
        tick();
        n_vec++; if (data_sram_rvalid !== 1'b1) begin n_err++; $display("FAIL basic_rd_rvalid: got %b want 1", data_sram_rvalid); end
        n_vec++; if (data_sram_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_rd_rdata: got %h want deadbeef", data_sram_rdata); end
        n_vec++; if (rd_cnt !== 32'h1) begin n_err++; $display("FAIL basic_rd_cnt: got %h want 1", rd_cnt); end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        n_vec++; if (data_sram_rvalid !== 1'b0) begin n_err++; $display("FAIL basic_pulse_end: got %b want 0", data_sram_rvalid); end
        n_vec++; if (data_sram_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_hold: got %h want deadbeef", data_sram_rdata); end
        n_vec++; if (data_sram_busy !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %b want 0", data_sram_busy); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_word [3];
        exp_word[0] = 32'hA0A0A0A0;
        exp_word[1] = 32'hB1B1B1B1;
        exp_word[2] = 32'hC2C2C2C2;
        for (int i = 0; i < 3; i++) do_write(4'hF, 32'(4 * i), exp_word[i]);
        drive(1'b1, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) drive(1'b1, 4'h0, 32'(4 * (i + 1)), 32'h0);
            else       drive(1'b0, 4'h0, 32'h0, 32'h0);
            n_vec++; if (data_sram_rvalid !== 1'b1) begin n_err++; $display("FAIL b2b_rvalid[%0d]: got %b want 1", i, data_sram_rvalid); end
            n_vec++; if (data_sram_rdata !== exp_word[i]) begin n_err++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, data_sram_rdata, exp_word[i]); end
        end
        tick();
        n_vec++; if (data_sram_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b want 0", data_sram_rvalid); end
    endtask
`endif

    task automatic test_byte_lanes;
        logic [31:0] d;
        bit          got;
        pulse_reset();
        do_write(4'hF, 32'h80, 32'h11223344);
        do_write(4'b0101, 32'h80, 32'hAABBCCDD);
        do_read(32'h80, d, got);
        n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL lanes_rvalid: got %b want 1", got); end
        n_vec++; if (d !== 32'h11BB33DD) begin n_err++; $display("FAIL lanes_rdata: got %h want 11bb33dd", d); end
        do_read(32'h83, d, got);
        n_vec++; if (d !== 32'h11BB33DD) begin n_err++; $display("FAIL lanes_addr_lsb: got %h want 11bb33dd", d); end
        n_vec++; if (wr_cnt !== 32'h2) begin n_err++; $display("FAIL lanes_wr_cnt: got %h want 2", wr_cnt); end
        n_vec++; if (rd_cnt !== 32'h2) begin n_err++; $display("FAIL lanes_rd_cnt: got %h want 2", rd_cnt); end
    endtask

    task automatic test_addr_err;
        logic [31:0] d;
        bit          got;
        pulse_reset();
        do_write(4'hF, 32'h0, 32'h600DF00D);
        n_vec++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b want 0", addr_err); end
        do_read(32'h00010000, d, got);
        n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL err_rd_rvalid: got %b want 1", got); end
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL err_rd_rdata: got %h want 0", d); end
        n_vec++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", addr_err); end
        do_write(4'hF, 32'h00010000, 32'hFFFFFFFF);
        do_read(32'h0, d, got);
        n_vec++; if (d !== 32'h600DF00D) begin n_err++; $display("FAIL err_wr_suppressed: got %h want 600df00d", d); end
        n_vec++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", addr_err); end
        n_vec++; if (rd_cnt !== 32'h2) begin n_err++; $display("FAIL err_rd_cnt: got %h want 2", rd_cnt); end
        n_vec++; if (wr_cnt !== 32'h2) begin n_err++; $display("FAIL err_wr_cnt: got %h want 2", wr_cnt); end
        pulse_reset();
        n_vec++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL err_reset: got %b want 0", addr_err); end
        do_read(32'h0, d, got);
        n_vec++; if (d !== 32'h600DF00D) begin n_err++; $display("FAIL err_mem_retained: got %h want 600df00d", d); end
    endtask

`ifdef DSRAM_WAIT_EN
    task automatic test_wait_latency;
        logic [31:0] d;
        bit          got;
        pulse_reset();
        do_write(4'hF, 32'h40, 32'hDEADBEEF);
        wait_idle();
        drive(1'b1, 4'h0, 32'h40, 32'h0);
        tick();
        n_vec++; if (data_sram_busy !== 1'b1) begin n_err++; $display("FAIL wait_busy_t1: got %b want 1", data_sram_busy); end
        n_vec++; if (data_sram_rvalid !== 1'b0) begin n_err++; $display("FAIL wait_rvalid_t1: got %b want 0", data_sram_rvalid); end
        drive(1'b1, 4'hF, 32'h40, 32'h0);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        n_vec++; if (data_sram_busy !== 1'b1) begin n_err++; $display("FAIL wait_busy_t2: got %b want 1", data_sram_busy); end
        n_vec++; if (data_sram_rvalid !== 1'b0) begin n_err++; $display("FAIL wait_rvalid_t2: got %b want 0", data_sram_rvalid); end
        tick();
        n_vec++; if (data_sram_busy !== 1'b1) begin n_err++; $display("FAIL wait_busy_t3: got %b want 1", data_sram_busy); end
        n_vec++; if (data_sram_rvalid !== 1'b1) begin n_err++; $display("FAIL wait_rvalid_t3: got %b want 1", data_sram_rvalid); end
        n_vec++; if (data_sram_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wait_rdata_t3: got %h want deadbeef", data_sram_rdata); end
        tick();
        n_vec++; if (data_sram_busy !== 1'b0) begin n_err++; $display("FAIL wait_busy_t4: got %b want 0", data_sram_busy); end
        n_vec++; if (data_sram_rvalid !== 1'b0) begin n_err++; $display("FAIL wait_rvalid_t4: got %b want 0", data_sram_rvalid); end
        n_vec++; if (rd_cnt !== 32'h1) begin n_err++; $display("FAIL wait_rd_cnt: got %h want 1", rd_cnt); end
        n_vec++; if (wr_cnt !== 32'h1) begin n_err++; $display("FAIL wait_wr_cnt: got %h want 1", wr_cnt); end
        do_read(32'h40, d, got);
        n_vec++; if (d !== 32'hDEADBEEF) begin n_err++; $display("FAIL wait_ignored_wr: got %h want deadbeef", d); end
    endtask

    task automatic test_wait_reset;
        logic [31:0] d;
        bit          got;
        pulse_reset();
        do_write(4'hF, 32'h100, 32'h12345678);
        wait_idle();
        drive(1'b1, 4'h0, 32'h100, 32'h0);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        reset = 1'b1;
        tick();
        n_vec++; if (data_sram_busy !== 1'b0) begin n_err++; $display("FAIL wrst_busy: got %b want 0", data_sram_busy); end
        n_vec++; if (data_sram_rvalid !== 1'b0) begin n_err++; $display("FAIL wrst_rvalid: got %b want 0", data_sram_rvalid); end
        n_vec++; if (rd_cnt !== 32'h0) begin n_err++; $display("FAIL wrst_rd_cnt: got %h want 0", rd_cnt); end
        n_vec++; if (wr_cnt !== 32'h0) begin n_err++; $display("FAIL wrst_wr_cnt: got %h want 0", wr_cnt); end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (data_sram_rvalid !== 1'b0) begin n_err++; $display("FAIL wrst_dropped[%0d]: got %b want 0", i, data_sram_rvalid); end
        end
        do_read(32'h100, d, got);
        n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL wrst_read_rvalid: got %b want 1", got); end
        n_vec++; if (d !== 32'h12345678) begin n_err++; $display("FAIL wrst_write_kept: got %h want 12345678", d); end
    endtask
`endif

    initial begin
        test_reset();
`ifndef DSRAM_WAIT_EN
        test_basic();
        test_back_to_back();
`endif
        test_byte_lanes();
        test_addr_err();
`ifdef DSRAM_WAIT_EN
        test_wait_latency();
        test_wait_reset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
